hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core: the stall/flush side of operand handling that the forwarding path cannot resolve. It consumes register-usage and memory-handshake status from the fetch, decode, execute, memory and writeback stages. It drives per-latch enable and flush signals plus the PC enable, sequences data-memory waits and halt, and keeps stall/flush performance counters. All latches between stages take their enable and flush from this block only.

---
 rtl/hazard_unit_pkg.sv | 6 +
 rtl/hazard_unit_if.sv | 24 ++
 rtl/hazard_unit.sv | 77 +++++++
 tb/tb_hazard_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared types and widths for the pipeline hazard controller
package hazard_unit_pkg;
   typedef logic [4:0] regbits_t;
   typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} hazard_state_t;
   localparam int FLUSH_W = 16;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: stage status in, latch/PC control and counters out
interface hazard_unit_if #(
   parameter int CNT_W = 32
);
   import hazard_unit_pkg::*;
   logic ihit, dhit, dmemREN_me, dmemWEN_me;
   regbits_t rs_de, rt_de, regDst_ex;
   logic usesRt_de, memToReg_ex, pcSrc_ex, halt_wb;
   logic pcEn, ifde_en, deex_en, exme_en, mewb_en, ifde_flush, deex_flush, halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [FLUSH_W-1:0] flush_cnt;
   modport hu (
      input  ihit, dhit, dmemREN_me, dmemWEN_me, rs_de, rt_de, usesRt_de,
             regDst_ex, memToReg_ex, pcSrc_ex, halt_wb,
      output pcEn, ifde_en, deex_en, exme_en, mewb_en, ifde_flush, deex_flush,
             halt, stall_cnt, flush_cnt
   );
   modport tb (
      output ihit, dhit, dmemREN_me, dmemWEN_me, rs_de, rt_de, usesRt_de,
             regDst_ex, memToReg_ex, pcSrc_ex, halt_wb,
      input  pcEn, ifde_en, deex_en, exme_en, mewb_en, ifde_flush, deex_flush,
             halt, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/halt sequencing for the five-stage pipeline latches
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic      CLK,
   input  logic      nRST,
   hazard_unit_if.hu hif
);
   hazard_state_t state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic active, mem_wait, load_use;
   logic pc_en, ifde_en, deex_en, exme_en, mewb_en, ifde_flush, deex_flush;

   assign active   = nRST && state_q != HALTED;
   assign mem_wait = (state_q == MEMWAIT || hif.dmemREN_me || hif.dmemWEN_me) && !hif.dhit;
   assign load_use = hif.memToReg_ex && hif.regDst_ex != '0 &&
                     (hif.regDst_ex == hif.rs_de || (hif.usesRt_de && hif.regDst_ex == hif.rt_de));

   // prioritised hazard resolution: halt, memory wait, redirect, load-use, fetch wait
   always_comb begin
      state_d    = state_q;
      pc_en      = 1'b0;
      ifde_en    = 1'b0;
      deex_en    = 1'b0;
      exme_en    = 1'b0;
      mewb_en    = 1'b0;
      ifde_flush = 1'b0;
      deex_flush = 1'b0;
      if (active) begin
         if (hif.halt_wb) state_d = HALTED;
         else if (mem_wait) state_d = MEMWAIT;
         else begin
            state_d    = RUN;
            pc_en      = hif.pcSrc_ex || (!load_use && hif.ihit);
            ifde_en    = hif.pcSrc_ex || !load_use;
            deex_en    = 1'b1;
            exme_en    = 1'b1;
            mewb_en    = 1'b1;
            ifde_flush = hif.pcSrc_ex || (!load_use && !hif.ihit);
            deex_flush = hif.pcSrc_ex || load_use;
         end
      end
   end

   // stall counter saturates, flush counter wraps; both idle once halted
   always_comb begin
      stall_cnt_d = (active && !pc_en && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
      flush_cnt_d = (ifde_flush || deex_flush) ? flush_cnt_q + 1'b1 : flush_cnt_q;
   end

   // state and counter registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hif.pcEn       = pc_en;
   assign hif.ifde_en    = ifde_en;
   assign hif.deex_en    = deex_en;
   assign hif.exme_en    = exme_en;
   assign hif.mewb_en    = mewb_en;
   assign hif.ifde_flush = ifde_flush;
   assign hif.deex_flush = deex_flush;
   assign hif.halt       = state_q == HALTED;
   assign hif.stall_cnt  = stall_cnt_q;
   assign hif.flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard priorities, counters, halt and reset
module tb_hazard_unit;
   logic CLK = 1'b0;
   logic nRST = 1'b0;
   int tests = 0;
   int fails = 0;
   logic [6:0] vec;

   always #5 CLK = ~CLK;

   hazard_unit_if #(.CNT_W(32)) h ();
   hazard_unit_if #(.CNT_W(4))  h4 ();
   hazard_unit #(.CNT_W(32)) dut  (.CLK(CLK), .nRST(nRST), .hif(h));
   hazard_unit #(.CNT_W(4))  dut4 (.CLK(CLK), .nRST(nRST), .hif(h4));

   // {pcEn, ifde_en, deex_en, exme_en, mewb_en, ifde_flush, deex_flush}
   assign vec = {h.pcEn, h.ifde_en, h.deex_en, h.exme_en, h.mewb_en, h.ifde_flush, h.deex_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      h.ihit = 1'b1; h.dhit = 1'b0; h.dmemREN_me = 1'b0; h.dmemWEN_me = 1'b0;
      h.rs_de = 5'd1; h.rt_de = 5'd2; h.usesRt_de = 1'b1; h.regDst_ex = 5'd0;
      h.memToReg_ex = 1'b0; h.pcSrc_ex = 1'b0; h.halt_wb = 1'b0;
   endtask

   initial begin
      idle();
      h4.ihit = 1'b0; h4.dhit = 1'b0; h4.dmemREN_me = 1'b0; h4.dmemWEN_me = 1'b0;
      h4.rs_de = 5'd1; h4.rt_de = 5'd2; h4.usesRt_de = 1'b0; h4.regDst_ex = 5'd0;
      h4.memToReg_ex = 1'b0; h4.pcSrc_ex = 1'b0; h4.halt_wb = 1'b0;
      h.pcSrc_ex = 1'b1;
      #12;
      chk("rst_outputs", vec, 7'b0000000);
      chk("rst_halt", h.halt, 1'b0);
      chk("rst_stall", h.stall_cnt, 0);
      chk("rst_flush", h.flush_cnt, 0);
      idle();
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      chk("normal", vec, 7'b1111100);
      chk("normal_stall", h.stall_cnt, 0);
      h.memToReg_ex = 1'b1; h.regDst_ex = 5'd5; h.rs_de = 5'd5;
      #1 chk("loaduse_rs", vec, 7'b0011101);
      tick();
      chk("loaduse_stall", h.stall_cnt, 1);
      chk("loaduse_flush", h.flush_cnt, 1);
      idle();
      #1 chk("after_bubble", vec, 7'b1111100);
      h.memToReg_ex = 1'b1; h.regDst_ex = 5'd2;
      #1 chk("loaduse_rt", vec, 7'b0011101);
      h.usesRt_de = 1'b0;
      #1 chk("rt_unused", vec, 7'b1111100);
      h.regDst_ex = 5'd0; h.rs_de = 5'd0; h.usesRt_de = 1'b1;
      #1 chk("loaduse_r0", vec, 7'b1111100);
      idle();
      tick();
      chk("idle_stall", h.stall_cnt, 1);
      h.ihit = 1'b0;
      #1 chk("fetch_wait", vec, 7'b0111110);
      tick();
      chk("fetch_stall", h.stall_cnt, 2);
      chk("fetch_flush", h.flush_cnt, 2);
      h.pcSrc_ex = 1'b1;
      #1 chk("redirect_nohit", vec, 7'b1111111);
      tick();
      chk("redirect_stall", h.stall_cnt, 2);
      chk("redirect_flush", h.flush_cnt, 3);
      idle();
      h.dmemREN_me = 1'b1;
      #1 chk("memwait_c1", vec, 7'b0000000);
      tick();
      chk("memwait_c2", vec, 7'b0000000);
      h.dmemREN_me = 1'b0;
      #1 chk("memwait_state_holds", vec, 7'b0000000);
      h.dmemREN_me = 1'b1;
      tick();
      chk("memwait_c3", vec, 7'b0000000);
      tick();
      chk("memwait_stall", h.stall_cnt, 5);
      h.dhit = 1'b1;
      #1 chk("memwait_dhit", vec, 7'b1111100);
      tick();
      chk("memwait_stall_after", h.stall_cnt, 5);
      h.dmemREN_me = 1'b0; h.dhit = 1'b0;
      #1 chk("back_to_run", vec, 7'b1111100);
      h.memToReg_ex = 1'b1; h.regDst_ex = 5'd5; h.rs_de = 5'd5;
      h.pcSrc_ex = 1'b1; h.dmemWEN_me = 1'b1; h.ihit = 1'b0;
      #1 chk("combo_memwait_wins", vec, 7'b0000000);
      tick();
      chk("combo_stall", h.stall_cnt, 6);
      chk("combo_flush", h.flush_cnt, 3);
      h.dhit = 1'b1;
      #1 chk("combo_dhit_redirect", vec, 7'b1111111);
      tick();
      chk("combo_dhit_flush", h.flush_cnt, 4);
      idle();
      h.halt_wb = 1'b1; h.ihit = 1'b0;
      #1 chk("halt_entry_outs", vec, 7'b0000000);
      chk("halt_entry_flag", h.halt, 1'b0);
      tick();
      chk("halt_set", h.halt, 1'b1);
      chk("halt_stall", h.stall_cnt, 7);
      h.halt_wb = 1'b0; h.pcSrc_ex = 1'b1; h.ihit = 1'b1;
      #1 chk("halted_outs", vec, 7'b0000000);
      tick();
      tick();
      chk("halted_sticky", h.halt, 1'b1);
      chk("halted_stall_frozen", h.stall_cnt, 7);
      chk("halted_flush_frozen", h.flush_cnt, 4);
      nRST = 1'b0;
      #1 chk("areset_halt", h.halt, 1'b0);
      chk("areset_stall", h.stall_cnt, 0);
      chk("areset_flush", h.flush_cnt, 0);
      chk("areset_outs", vec, 7'b0000000);
      idle();
      nRST = 1'b1;
      #1 chk("release_run", vec, 7'b1111100);
      h.dmemREN_me = 1'b1;
      tick();
      h.dmemREN_me = 1'b0;
      #1 chk("pre_reset_memwait", vec, 7'b0000000);
      nRST = 1'b0;
      #1 nRST = 1'b1;
      #1 chk("reset_exits_memwait", vec, 7'b1111100);
      chk("reset_memwait_stall", h.stall_cnt, 0);
      for (int i = 0; i < 14; i++) tick();
      chk("sat_pre", h4.stall_cnt, 14);
      chk("sat_pre_flush", h4.flush_cnt, 14);
      for (int i = 0; i < 6; i++) tick();
      chk("sat_hold", h4.stall_cnt, 4'hF);
      chk("sat_flush", h4.flush_cnt, 20);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
